// File: rtl/scytale_pkg.sv
// Shared definitions for the scytale encryptor and decryptor.
//   - default start tokens for both directions
//   - pad character emitted for positions beyond the stored message
//   - FSM state encoding
//   - address width helper: wide enough to hold the value MAX_NOF_CHARS itself
package scytale_pkg;

  localparam logic [7:0] START_ENCRYPTION_TOKEN_DEF = 8'hFA;
  localparam logic [7:0] START_DECRYPTION_TOKEN_DEF = 8'hFA;
  localparam logic [7:0] PAD_CHAR                   = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One bit more than needed to index the buffer, so a full count fits.
  function automatic int addr_width(input int max_chars);
    return $clog2(max_chars) + 1;
  endfunction

endpackage

// File: rtl/scytale_char_buffer.sv
// Character buffer for the scytale blocks.
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears the count only)
//   wr_en      write wr_data at the current count; ignored when full
//   wr_data    character to store
//   clr        empty the buffer (count back to zero)
//   rd_addr    combinational read address
//   rd_data    stored character, or the pad character when rd_addr >= count
module scytale_char_buffer
  import scytale_pkg::*;
#(
  parameter int D_WIDTH       = 8,
  parameter int MAX_NOF_CHARS = 50,
  localparam int AW           = addr_width(MAX_NOF_CHARS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               clr,
  input  logic [AW-1:0]      rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem_reg [MAX_NOF_CHARS];
  logic [AW-1:0]      count_reg;
  logic               full;
  logic               do_write;

  assign full     = (count_reg == AW'(MAX_NOF_CHARS));
  assign do_write = wr_en && !full;

  // Storage has no reset: only the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_reg[count_reg[AW-2:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (do_write) begin
      count_reg <= count_reg + AW'(1);
    end
  end

  // Count never exceeds MAX_NOF_CHARS, so the pad test also guards the index.
  assign rd_data = (rd_addr >= count_reg) ? D_WIDTH'(PAD_CHAR)
                                          : mem_reg[rd_addr[AW-2:0]];

endmodule

// File: rtl/scytale_encryption.sv
// Scytale transposition encryptor.
// Collects plaintext until the start token, then emits the key_N x key_M
// ciphertext one character per cycle: c[i*N + j] = p[j*M + i].
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   data_i     plaintext character or start token, qualified by valid_i
//   key_N      columns (characters per ciphertext row), sampled in START
//   key_M      rows, sampled in START
//   data_o     ciphertext character, qualified by valid_o
//   busy       high from token acceptance until the end of DONE
module scytale_encryption
  import scytale_pkg::*;
#(
  parameter int                  D_WIDTH                = 8,
  parameter int                  KEY_WIDTH              = 8,
  parameter int                  MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]  START_ENCRYPTION_TOKEN = D_WIDTH'(START_ENCRYPTION_TOKEN_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int AW  = addr_width(MAX_NOF_CHARS);
  localparam int L_W = 2 * KEY_WIDTH;

  state_t               state_reg,   state_next;
  logic                 busy_reg,    busy_next;
  logic                 valid_reg,   valid_next;
  logic [D_WIDTH-1:0]   data_reg,    data_next;
  logic [KEY_WIDTH-1:0] n_reg,       n_next;
  logic [KEY_WIDTH-1:0] m_reg,       m_next;
  logic [L_W-1:0]       len_reg,     len_next;
  logic [AW-1:0]        addr_reg,    addr_next;
  logic [AW-1:0]        i_reg,       i_next;
  logic [AW-1:0]        j_reg,       j_next;
  logic [AW-1:0]        out_cnt_reg, out_cnt_next;

  logic                 wr_en;
  logic                 buf_clr;
  logic [D_WIDTH-1:0]   rd_data;
  logic [L_W-1:0]       len_prod;
  logic                 len_legal;
  logic                 last_col;
  logic                 last_out;

  scytale_char_buffer #(
    .D_WIDTH       (D_WIDTH),
    .MAX_NOF_CHARS (MAX_NOF_CHARS)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (data_i),
    .clr     (buf_clr),
    .rd_addr (addr_reg),
    .rd_data (rd_data)
  );

  // Only IDLE accepts input; the token itself is never stored.
  assign wr_en   = (state_reg == IDLE) && valid_i && (data_i != START_ENCRYPTION_TOKEN);
  assign buf_clr = (state_reg == DONE);

  assign len_prod  = L_W'(key_N) * L_W'(key_M);
  assign len_legal = (len_prod != '0) && (len_prod <= L_W'(MAX_NOF_CHARS));

  // Compare in the wide domain so key_N - 1 cannot wrap into a small j.
  assign last_col = (L_W'(j_reg) == (L_W'(n_reg) - L_W'(1)));
  assign last_out = (L_W'(out_cnt_reg) == (len_reg - L_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      n_reg       <= '0;
      m_reg       <= '0;
      len_reg     <= '0;
      addr_reg    <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      out_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      busy_reg    <= busy_next;
      valid_reg   <= valid_next;
      data_reg    <= data_next;
      n_reg       <= n_next;
      m_reg       <= m_next;
      len_reg     <= len_next;
      addr_reg    <= addr_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    busy_next    = busy_reg;
    valid_next   = 1'b0;
    data_next    = '0;
    n_next       = n_reg;
    m_next       = m_reg;
    len_next     = len_reg;
    addr_next    = addr_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    out_cnt_next = out_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (valid_i && (data_i == START_ENCRYPTION_TOKEN)) begin
          busy_next  = 1'b1;
          state_next = START;
        end
      end

      START: begin
        n_next       = key_N;
        m_next       = key_M;
        len_next     = len_prod;
        addr_next    = '0;
        i_next       = '0;
        j_next       = '0;
        out_cnt_next = '0;
        state_next   = len_legal ? EMIT : DONE;
      end

      EMIT: begin
        valid_next   = 1'b1;
        data_next    = rd_data;
        out_cnt_next = out_cnt_reg + AW'(1);
        // Walk down a column by stepping M; at the end of a ciphertext row
        // the next row starts at plaintext index i+1. M <= MAX_NOF_CHARS
        // whenever L is legal, so the truncating cast is lossless.
        if (last_col) begin
          i_next    = i_reg + AW'(1);
          j_next    = '0;
          addr_next = i_reg + AW'(1);
        end else begin
          j_next    = j_reg + AW'(1);
          addr_next = addr_reg + AW'(m_reg);
        end
        if (last_out) begin
          state_next = DONE;
        end
      end

      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_scytale_encryption.sv
// Bench for scytale_encryption: a queue-based plaintext model and the
// transposition formula c[i*N + j] = p[j*M + i] give the expected ciphertext.
module tb_scytale_encryption;

  localparam int         MAXC  = 50;
  localparam logic [7:0] TOKEN = 8'hFA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] plain_q [$];

  always #5 clk = ~clk;

  scytale_encryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (c == TOKEN);
    return c;
  endfunction

  task automatic send_char(input logic [7:0] c);
    data_i  = c;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    if (plain_q.size() < MAXC) plain_q.push_back(c);
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send_char(s[k]);
  endtask

  // Issue the token, collect the burst, compare with the model.
  // junk=1 drives random characters/tokens and changes the keys while busy.
  task automatic run_msg(input string name, input int n, input int m, input bit junk);
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int  len, first, last, busy_cyc, idx;
    bit  legal, done;

    len   = n * m;
    legal = (len != 0) && (len <= MAXC);
    if (legal) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) begin
          idx = j * m + i;
          exp_q.push_back(idx < plain_q.size() ? plain_q[idx] : 8'h00);
        end
    end

    key_N   = 8'(n);
    key_M   = 8'(m);
    data_i  = TOKEN;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check({name, ".busy_after_token"}, 32'(busy), 32'd1);

    first = -1; last = -1; busy_cyc = 1; done = 1'b0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      if (junk) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = ($urandom_range(0, 3) == 0) ? TOKEN : rand_char();
        if (cyc >= 2) begin
          key_N = 8'($urandom_range(0, 255));
          key_M = 8'($urandom_range(0, 255));
        end
      end
      tick();
      if (valid_o) begin
        got_q.push_back(data_o);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (busy) busy_cyc++;
      else done = 1'b1;
    end
    valid_i = 1'b0;

    check({name, ".busy_falls"}, 32'(done), 32'd1);
    check({name, ".busy_cycles"}, 32'(busy_cyc), legal ? 32'(len + 2) : 32'd2);
    check({name, ".n_outputs"}, 32'(got_q.size()), 32'(exp_q.size()));
    if (legal) begin
      check({name, ".first_out"}, 32'(first), 32'd2);
      check({name, ".no_gaps"}, 32'(last - first + 1), 32'(len));
      for (int k = 0; k < exp_q.size(); k++)
        check($sformatf("%s.c%0d", name, k),
              k < got_q.size() ? 32'(got_q[k]) : 32'hDEAD_BEEF, 32'(exp_q[k]));
    end
    check({name, ".valid_idle"}, 32'(valid_o), 32'd0);
    check({name, ".data_idle"}, 32'(data_o), 32'd0);
    $display("msg %s: N=%0d M=%0d stored=%0d outputs=%0d busy=%0d junk=%0d",
             name, n, m, plain_q.size(), got_q.size(), busy_cyc, junk);
    plain_q.delete();
  endtask

  initial begin
    int n, m, cnt;

    rst = 1'b1; data_i = '0; valid_i = 1'b0; key_N = '0; key_M = '0;
    tick(); tick();
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.valid", 32'(valid_o), 32'd0);
    check("reset.data", 32'(data_o), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset.busy", 32'(busy), 32'd0);

    send_str("ABCDEF"); run_msg("n3m2", 3, 2, 1'b0);
    send_str("ABCDEF"); run_msg("n2m3", 2, 3, 1'b0);
    send_str("ABCD");   run_msg("short_pad", 3, 2, 1'b0);
    send_str("ABC");    run_msg("n0_illegal", 0, 3, 1'b0);
    send_str("ABCDEF"); run_msg("after_n0", 3, 2, 1'b0);
    send_str("ABCDEF"); run_msg("l64_illegal", 8, 8, 1'b0);
    send_str("ABCDEF"); run_msg("after_l64", 2, 3, 1'b0);

    // Reset while the third output (E) is on the bus.
    send_str("ABCDEF");
    key_N = 8'd3; key_M = 8'd2; data_i = TOKEN; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midrst.valid_before", 32'(valid_o), 32'd1);
    check("midrst.data_before", 32'(data_o), 32'h45);
    rst = 1'b1;
    tick();
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.valid", 32'(valid_o), 32'd0);
    check("midrst.data", 32'(data_o), 32'd0);
    rst = 1'b0;
    plain_q.delete();
    $display("msg midrst: reset on third output cycle");
    send_str("WXYZ"); run_msg("after_rst", 2, 2, 1'b0);

    send_str("ABCDEF"); run_msg("junk_emit", 3, 2, 1'b1);

    for (int k = 0; k < 51; k++) send_char(rand_char());
    run_msg("overflow51", 5, 10, 1'b0);

    for (int r = 0; r < 10; r++) begin
      n   = $urandom_range(1, 10);
      m   = $urandom_range(1, MAXC / n);
      cnt = $urandom_range(0, 55);
      for (int k = 0; k < cnt; k++) send_char(rand_char());
      run_msg($sformatf("rand%0d", r), n, m, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scytale_encryption.md
# scytale_encryption

Scytale transposition encryptor, the transmit-side counterpart of the scytale decryptor. It buffers a plaintext character stream until a start token arrives. It then emits the N×M ciphertext one character per cycle, in the order the decryptor expects. It sits on the same byte-stream interface (data/valid in, data/valid/busy out) as the rest of the cipher blocks.

## Interface
- `D_WIDTH`, 8, character width
- `KEY_WIDTH`, 8, width of each key
- `MAX_NOF_CHARS`, 50, buffer depth in characters
- `START_ENCRYPTION_TOKEN`, 8'hFA, end-of-plaintext / start-of-encryption marker
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset
- `data_i`  in  D_WIDTH  plaintext character or token
- `valid_i`  in  1  `data_i` qualifier
- `key_N`  in  KEY_WIDTH  columns, i.e. characters per ciphertext row
- `key_M`  in  KEY_WIDTH  rows
- `data_o`  out  D_WIDTH  ciphertext character; reset value 0
- `valid_o`  out  1  `data_o` qualifier; reset value 0
- `busy`  out  1  high while encrypting; reset value 0

## Operation
- **Message geometry.** Plaintext p has length L = key_N*key_M. Ciphertext rule: c[i*N + j] = p[j*M + i], for i in 0..M-1 and j in 0..N-1.
- **Collect phase (IDLE).** A non-token character with `valid_i=1` is written to buf[count], and count increments.
  - Characters arriving when count == MAX_NOF_CHARS are dropped.
- **Token acceptance.** `valid_i=1` with `data_i` equal to the token, while in IDLE:
  - sets `busy`;
  - goes to START;
  - the token itself is not stored.
- **START (1 cycle).**
  - Latch key_N and key_M.
  - Compute L as a 2*KEY_WIDTH-bit product.
  - If L==0 or L>MAX_NOF_CHARS, go to DONE with no output. Otherwise go to EMIT.
- **EMIT (L cycles).** Each cycle drives `data_o` from the read address and sets `valid_o=1`.
  - The read address is the value of p to output. Reading at addr >= count outputs 8'h00 (pad).
  - Address walk, incremental with no multiplier: start addr=0, i=0, j=0.
  - Each cycle: addr += M and j += 1.
  - When j == N-1: set i += 1, j = 0, addr = i+1 (the new row index).
  - Leave EMIT after L outputs.
- **DONE (1 cycle).** `valid_o<=0`, `data_o<=0`, `busy<=0`, count<=0, then return to IDLE.
- **While busy.** `valid_i` is ignored, tokens included. A character arriving on the same cycle `busy` falls (DONE) is ignored.
- **Count vs. L.** If count > L, only the first L characters are encrypted. The remainder is discarded at DONE.
- **Reset.** Reset at any point, including mid-EMIT, returns to IDLE and clears count and all outputs next edge. Buffer contents need not be cleared.
- **Arithmetic widths.**
  - L is 16 bits.
  - addr, i, j and the output counter are $clog2(MAX_NOF_CHARS)+1 bits.
  - addr never exceeds L-1 when L is legal.

## Timing
- Edge E0: token sampled, `busy`=1 after E0.
- E1: START evaluation.
- E2..E(L+1): outputs 0..L-1. `valid_o` is high for exactly L consecutive cycles with no gaps.
- E(L+2): `busy`, `valid_o` and `data_o` are 0.
- Total `busy` time: L+2 cycles. For an illegal key, `busy` is high 2 cycles and `valid_o` never asserts.
- A first plaintext character is accepted the cycle after `busy` falls.
- No output backpressure: the downstream must accept every `valid_o` cycle.

## Structure
- Shared package `scytale_pkg`, common to encryptor and decryptor, holds:
  - the `START_*_TOKEN` default 8'hFA;
  - the pad value 8'h00;
  - the state enum {IDLE, START, EMIT, DONE};
  - an address-width function of MAX_NOF_CHARS.
- One sub-module, `scytale_char_buffer`, provides:
  - MAX_NOF_CHARS×D_WIDTH storage;
  - the write port and count, with drop-when-full;
  - a combinational read port with pad-on-addr>=count.
- The FSM and address walk live in the top module.

## Test plan
- "ABCDEF", N=3, M=2, then 0xFA → `valid_o` for 6 cycles starting 2 cycles after the token: A,C,E,B,D,F. `busy` is high 8 cycles.
- Same text, N=2, M=3 → A,D,B,E,C,F. Feeding this output into the decryptor with N=2, M=3 recovers "ABCDEF".
- "ABCD", N=3, M=2 → A,C,00,B,D,00 (short message padded).
- N=0, and separately N=8 with M=8 (L=64>50) → `busy` high 2 cycles and no `valid_o`. The next message encrypts correctly.
- `rst` asserted on the 3rd output cycle of "ABCDEF" → next cycle `busy`=0, `valid_o`=0, `data_o`=0. A following "WXYZ" with N=2, M=2 gives W,Y,X,Z.
- Characters plus a token driven on `valid_i` during EMIT are ignored, with output unchanged. Input of 51 characters with N=5, M=10 → the 51st is dropped and the output uses the first 50.
